// File: rtl/add_sub_pkg.sv
// Shared types for the add/subtract front end: loader FSM states,
// default operand width and the state_led encodings.
package add_sub_pkg;

   localparam int OPERAND_W = 6;

   typedef enum logic [1:0] {
      WAIT_A,
      WAIT_B,
      SHOW
   } loader_state_t;

   localparam logic [1:0] LED_WAIT_A = 2'b01;
   localparam logic [1:0] LED_WAIT_B = 2'b10;
   localparam logic [1:0] LED_SHOW   = 2'b11;

   function automatic logic [1:0] state_led_of(input loader_state_t s);
      logic [1:0] led;
      led = LED_WAIT_A;
      unique case (s)
         WAIT_A:  led = LED_WAIT_A;
         WAIT_B:  led = LED_WAIT_B;
         SHOW:    led = LED_SHOW;
         default: led = LED_WAIT_A;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Operand bundle handed from operand_loader (master) to the
// arithmetic/display stage (slave): A/B, select, valid, strobe, LEDs.
interface operand_loader_if #(
   parameter int WIDTH = 6
);

   logic [WIDTH-1:0] A_out;
   logic [WIDTH-1:0] B_out;
   logic             add_sub_out;
   logic             operands_valid;
   logic             load_strobe;
   logic [1:0]       state_led;

   modport master (
      output A_out, B_out, add_sub_out,
      output operands_valid, load_strobe, state_led
   );

   modport slave (
      input A_out, B_out, add_sub_out,
      input operands_valid, load_strobe, state_led
   );

endinterface

// File: rtl/btn_debounce.sv
// Active-low push-button conditioner: 2-flop sync, debounce counter,
// stable level, one-cycle press_evt on a debounced 1->0 transition.
// Ports: clk, rst_n (sync, active-low), btn_raw in;
//        stable (debounced level), press_evt (pulse) out.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic stable,
   output logic press_evt
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          evt_q, evt_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // Only presses (stable falling) raise an event.
      evt_d = stable_q & ~stable_d;
   end

   // Stable resets to "pressed" so a button held through reset
   // has to be released and pressed again before it counts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         evt_q    <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         evt_q    <= evt_d;
      end
   end

   assign stable    = stable_q;
   assign press_evt = evt_q;

endmodule

// File: rtl/operand_loader.sv
// Operand-entry front end: press 1 captures A, press 2 captures B and
// the add/sub select, then presents the committed pair downstream.
// Ports: clk, rst_n (sync, active-low), sw, sw_add_sub, button (raw,
//        active-low) in; out_if (operand_loader_if.master) out.
// Option: LONG_PRESS_CLEAR_EN adds a hold-to-clear long press.
module operand_loader
   import add_sub_pkg::*;
#(
   parameter int WIDTH             = OPERAND_W,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             sw_add_sub,
   input  logic             button,
   operand_loader_if.master out_if
);

   logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
   logic             sel_s1_q, sel_s2_q;
   logic             btn_stable;
   logic             press_evt;

   loader_state_t    state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             strobe_q, strobe_d;
   logic             lp_fire;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (button),
      .stable   (btn_stable),
      .press_evt(press_evt)
   );

`ifdef LONG_PRESS_CLEAR_EN
   localparam int LPW = $clog2(LONG_PRESS_CYCLES);
   localparam logic [LPW-1:0] LP_LAST = LPW'(LONG_PRESS_CYCLES - 1);
   localparam logic [LPW-1:0] LP_PRE  = LPW'(LONG_PRESS_CYCLES - 2);

   logic [LPW-1:0] lp_cnt_q, lp_cnt_d;

   // Counter parks at its last value so a hold fires only once.
   always_comb begin
      lp_cnt_d = lp_cnt_q;
      lp_fire  = 1'b0;
      if (btn_stable) begin
         lp_cnt_d = '0;
      end else if (lp_cnt_q != LP_LAST) begin
         lp_cnt_d = lp_cnt_q + 1'b1;
         lp_fire  = (lp_cnt_q == LP_PRE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) lp_cnt_q <= '0;
      else        lp_cnt_q <= lp_cnt_d;
   end
`else
   logic unused_stable;
   assign unused_stable = btn_stable;
   assign lp_fire       = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      valid_d  = valid_q;
      strobe_d = 1'b0;
      if (press_evt) begin
         unique case (state_q)
            WAIT_A, SHOW: begin
               a_d     = sw_s2_q;
               valid_d = 1'b0;
               state_d = WAIT_B;
            end
            WAIT_B: begin
               b_d      = sw_s2_q;
               sel_d    = sel_s2_q;
               valid_d  = 1'b1;
               strobe_d = 1'b1;
               state_d  = SHOW;
            end
            default: state_d = WAIT_A;
         endcase
      end
      // Long-press clear overrides whatever the press did.
      if (lp_fire) begin
         state_d = WAIT_A;
         a_d     = '0;
         b_d     = '0;
         sel_d   = 1'b0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         sel_s1_q <= 1'b0;
         sel_s2_q <= 1'b0;
         state_q  <= WAIT_A;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= 1'b0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
         sel_s1_q <= sw_add_sub;
         sel_s2_q <= sel_s1_q;
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
      end
   end

   assign out_if.A_out          = a_q;
   assign out_if.B_out          = b_q;
   assign out_if.add_sub_out    = sel_q;
   assign out_if.operands_valid = valid_q;
   assign out_if.load_strobe    = strobe_q;
   assign out_if.state_led      = state_led_of(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20;
// expectations follow LONG_PRESS_CLEAR_EN when it is defined.
module tb_operand_loader;

   localparam int W = 6;

   typedef struct {
      logic [W-1:0] sw;
      logic         sel;
      int           hold;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic         v;
      logic [1:0]   led;
      logic         commit;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw;
   logic         sw_add_sub;
   logic         button;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2*W:0] sb[$];
   vec_t         tbl[5];

   operand_loader_if #(.WIDTH(W)) ol_if ();

   operand_loader #(
      .WIDTH            (W),
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .sw_add_sub(sw_add_sub),
      .button    (button),
      .out_if    (ol_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic v, input logic [1:0] led);
      chk({tag, "_A"},   32'(ol_if.A_out), 32'(a));
      chk({tag, "_B"},   32'(ol_if.B_out), 32'(b));
      chk({tag, "_sel"}, 32'(ol_if.add_sub_out), 32'(s));
      chk({tag, "_vld"}, 32'(ol_if.operands_valid), 32'(v));
      chk({tag, "_led"}, 32'(ol_if.state_led), 32'(led));
   endtask

   task automatic press(input string tag, input vec_t t);
      int strobes;
      strobes    = 0;
      sw         = t.sw;
      sw_add_sub = t.sel;
      if (t.commit) sb.push_back({t.a, t.b, t.s});
      repeat (3) tick();
      button = 1'b0;
      repeat (t.hold) begin
         tick();
         if (ol_if.load_strobe) strobes++;
      end
      button = 1'b1;
      repeat (12) begin
         tick();
         if (ol_if.load_strobe) strobes++;
      end
      chk_out(tag, t.a, t.b, t.s, t.v, t.led);
      chk({tag, "_strobes"}, 32'(strobes), 32'(t.commit));
   endtask

   // Scoreboard: every load_strobe must match the oldest queued pair.
   always @(negedge clk) begin
      if (ol_if.load_strobe === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_strobe", 32'd1, 32'd0);
         end else begin
            logic [2*W:0] e;
            e = sb.pop_front();
            chk("sb_A",   32'(ol_if.A_out), 32'(e[2*W:W+1]));
            chk("sb_B",   32'(ol_if.B_out), 32'(e[W:1]));
            chk("sb_sel", 32'(ol_if.add_sub_out), 32'(e[0]));
            chk("sb_vld", 32'(ol_if.operands_valid), 32'd1);
         end
      end
   end

   initial begin
      vec_t t;
      int   strobes;

      tbl[0] = '{6'd61, 1'b1, 10, 6'd5,  6'd61, 1'b1, 1'b1, 2'b11, 1'b1};
      tbl[1] = '{6'd9,  1'b0, 10, 6'd9,  6'd61, 1'b1, 1'b0, 2'b10, 1'b0};
      tbl[2] = '{6'd31, 1'b0, 10, 6'd9,  6'd31, 1'b0, 1'b1, 2'b11, 1'b1};
      tbl[3] = '{6'd32, 1'b1, 10, 6'd32, 6'd31, 1'b0, 1'b0, 2'b10, 1'b0};
      tbl[4] = '{6'd63, 1'b1, 10, 6'd32, 6'd63, 1'b1, 1'b1, 2'b11, 1'b1};

      // Reset with the button held down, then release.
      rst_n      = 1'b0;
      button     = 1'b0;
      sw         = '0;
      sw_add_sub = 1'b0;
      repeat (3) tick();
      chk_out("rst", '0, '0, 1'b0, 1'b0, 2'b01);
      chk("rst_strobe", 32'(ol_if.load_strobe), 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      button = 1'b1;
      repeat (10) tick();
      chk_out("held_rst", '0, '0, 1'b0, 1'b0, 2'b01);

      // Exact press latency: A lands on the 7th edge after onset.
      sw = 6'd5;
      repeat (3) tick();
      button = 1'b0;
      repeat (6) tick();
      chk("lat_A_early", 32'(ol_if.A_out), 32'd0);
      tick();
      chk_out("lat", 6'd5, '0, 1'b0, 1'b0, 2'b10);
      repeat (3) tick();
      button = 1'b1;
      repeat (12) tick();

      for (int i = 0; i < 5; i++) begin
         press($sformatf("tbl%0d", i), tbl[i]);
      end

      // Bounce: 2-cycle toggles never survive debounce.
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         button = ~button;
         tick();
         tick();
         if (ol_if.load_strobe) strobes++;
      end
      button = 1'b1;
      repeat (10) tick();
      chk_out("bounce", 6'd32, 6'd63, 1'b1, 1'b1, 2'b11);
      chk("bounce_strobes", 32'(strobes), 32'd0);

      // Switch change without a press is ignored.
      sw = 6'd9;
      repeat (8) tick();
      chk_out("sw_only", 6'd32, 6'd63, 1'b1, 1'b1, 2'b11);
      t = '{6'd9, 1'b0, 10, 6'd9, 6'd63, 1'b1, 1'b0, 2'b10, 1'b0};
      press("show_press", t);

      // Reset in the middle of a debounce.
      sw = 6'd4;
      repeat (3) tick();
      button = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      chk_out("mid_rst", '0, '0, 1'b0, 1'b0, 2'b01);
      chk("mid_rst_strobe", 32'(ol_if.load_strobe), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      button = 1'b1;
      repeat (12) tick();

      t = '{6'd7, 1'b0, 10, 6'd7, 6'd0, 1'b0, 1'b0, 2'b10, 1'b0};
      press("re_A", t);
      t = '{6'd2, 1'b0, 10, 6'd7, 6'd2, 1'b0, 1'b1, 2'b11, 1'b1};
      press("re_B", t);

      // Long hold in SHOW.
`ifdef LONG_PRESS_CLEAR_EN
      t = '{6'd11, 1'b1, 30, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01, 1'b0};
`else
      t = '{6'd11, 1'b1, 30, 6'd11, 6'd2, 1'b0, 1'b0, 2'b10, 1'b0};
`endif
      press("long", t);

      chk("sb_left", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
